// File: rtl/ram_3port_ctrl.sv
// ----------------------------------------------------------------------------
// ram_3port_ctrl
//
// Request-side controller in front of the 1-write/2-read register-file RAM.
// After reset it sweeps INIT_VALUE into every RAM location. It then passes one
// write channel and two read channels straight through to the independent RAM
// ports. Read responses come back one cycle after acceptance.
//
// Optional feature (compile-time macro RAM_FWD_EN):
//   When the macro is defined, a read that collides with a same-cycle write
//   (same address, both accepted) returns the new write data.
//   When it is undefined, such a read returns the RAM's pre-write word.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   init_done_o                  high once the init sweep has finished
//   wr_valid_i / wr_ready_o      write handshake
//   wr_addr_i / wr_data_i        write address and data
//   rdN_valid_i / rdN_ready_o    read handshake, N = 1, 2
//   rdN_addr_i                   read address
//   rdN_resp_valid_o             one-cycle response pulse
//   rdN_resp_data_o              response data, 0 while rdN_resp_valid_o is low
//   ram_write_en_o / ram_write_addr_o / ram_write_data_o   RAM write port
//   ram_read_addrN_o             RAM read port N address
//   ram_read_dataN_i             RAM read port N data (one-cycle latency)
// ----------------------------------------------------------------------------
module ram_3port_ctrl #(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  init_done_o,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd1_valid_i,
    output logic                  rd1_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd1_addr_i,
    output logic                  rd1_resp_valid_o,
    output logic [DATA_WIDTH-1:0] rd1_resp_data_o,
    input  logic                  rd2_valid_i,
    output logic                  rd2_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd2_addr_i,
    output logic                  rd2_resp_valid_o,
    output logic [DATA_WIDTH-1:0] rd2_resp_data_o,
    output logic                  ram_write_en_o,
    output logic [ADDR_WIDTH-1:0] ram_write_addr_o,
    output logic [DATA_WIDTH-1:0] ram_write_data_o,
    output logic [ADDR_WIDTH-1:0] ram_read_addr1_o,
    output logic [ADDR_WIDTH-1:0] ram_read_addr2_o,
    input  logic [DATA_WIDTH-1:0] ram_read_data1_i,
    input  logic [DATA_WIDTH-1:0] ram_read_data2_i
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    // One extra bit so the terminal count never aliases back to address 0.
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] sweepCnt_q, sweepCnt_d;
    logic                 running;
    logic                 rd1Accept, rd2Accept;
    logic                 rd1Pend_q, rd2Pend_q;

    // Holding reset masks every handshake, so nothing is accepted in a reset cycle.
    assign running   = (state_q == ST_RUN) && !rst_i;
    assign rd1Accept = rd1_valid_i && running;
    assign rd2Accept = rd2_valid_i && running;

    // State register and sweep counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            sweepCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sweepCnt_q <= sweepCnt_d;
        end
    end

    // Next state: the sweep advances one address per cycle and hands over to
    // RUN right after the last location has been written.
    always_comb begin
        state_d    = state_q;
        sweepCnt_d = sweepCnt_q;
        case (state_q)
            ST_INIT: begin
                sweepCnt_d = sweepCnt_q + 1'b1;
                if (sweepCnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Outputs: in INIT the write port is owned by the sweep. In RUN all three
    // channels map straight onto their own RAM port, so no arbitration is needed.
    always_comb begin
        init_done_o      = running;
        wr_ready_o       = running;
        rd1_ready_o      = running;
        rd2_ready_o      = running;
        ram_read_addr1_o = rd1_addr_i;
        ram_read_addr2_o = rd2_addr_i;
        ram_write_en_o   = 1'b0;
        ram_write_addr_o = wr_addr_i;
        ram_write_data_o = wr_data_i;
        if (state_q == ST_INIT) begin
            ram_write_en_o   = !rst_i;
            ram_write_addr_o = sweepCnt_q[ADDR_WIDTH-1:0];
            ram_write_data_o = INIT_VALUE;
        end else begin
            ram_write_en_o   = wr_valid_i && running;
        end
    end

    // Accepted reads become a response exactly one cycle later, in step with
    // the RAM's registered read data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd1Pend_q <= 1'b0;
            rd2Pend_q <= 1'b0;
        end else begin
            rd1Pend_q <= rd1Accept;
            rd2Pend_q <= rd2Accept;
        end
    end

`ifdef RAM_FWD_EN
    logic                  wrAccept;
    logic                  rd1Hit_q, rd2Hit_q;
    logic [DATA_WIDTH-1:0] rd1Fwd_q, rd2Fwd_q;

    assign wrAccept = wr_valid_i && running;

    // The RAM hands back the old word on a same-cycle collision, so capture
    // the write data and remember that this channel must use it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd1Hit_q <= 1'b0;
            rd2Hit_q <= 1'b0;
            rd1Fwd_q <= '0;
            rd2Fwd_q <= '0;
        end else begin
            rd1Hit_q <= wrAccept && rd1Accept && (wr_addr_i == rd1_addr_i);
            rd2Hit_q <= wrAccept && rd2Accept && (wr_addr_i == rd2_addr_i);
            rd1Fwd_q <= wr_data_i;
            rd2Fwd_q <= wr_data_i;
        end
    end
`endif

    // A response still pending when reset arrives is dropped, not delivered.
    always_comb begin
        rd1_resp_valid_o = rd1Pend_q && !rst_i;
        rd2_resp_valid_o = rd2Pend_q && !rst_i;
        rd1_resp_data_o  = '0;
        rd2_resp_data_o  = '0;
`ifdef RAM_FWD_EN
        if (rd1Pend_q && !rst_i) rd1_resp_data_o = rd1Hit_q ? rd1Fwd_q : ram_read_data1_i;
        if (rd2Pend_q && !rst_i) rd2_resp_data_o = rd2Hit_q ? rd2Fwd_q : ram_read_data2_i;
`else
        if (rd1Pend_q && !rst_i) rd1_resp_data_o = ram_read_data1_i;
        if (rd2Pend_q && !rst_i) rd2_resp_data_o = ram_read_data2_i;
`endif
    end

endmodule

// File: tb/tb_ram_3port_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_3port_ctrl
//
// Bench for ram_3port_ctrl. It contains a behavioural RAM on the raw ports, a
// plain-array reference model of memory contents and of the init sweep, and a
// queue-based scoreboard for read responses. Honours RAM_FWD_EN like the design.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_3port_ctrl;

    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] INIT_VAL = '0;
`ifdef RAM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_done;
    logic          wr_valid = 1'b0, wr_ready;
    logic [AW-1:0] wr_addr  = '0;
    logic [DW-1:0] wr_data  = '0;
    logic          rd1_valid = 1'b0, rd1_ready, rd1_resp_valid;
    logic [AW-1:0] rd1_addr  = '0;
    logic [DW-1:0] rd1_resp_data;
    logic          rd2_valid = 1'b0, rd2_ready, rd2_resp_valid;
    logic [AW-1:0] rd2_addr  = '0;
    logic [DW-1:0] rd2_resp_data;
    logic          ram_write_en;
    logic [AW-1:0] ram_write_addr, ram_read_addr1, ram_read_addr2;
    logic [DW-1:0] ram_write_data;
    logic [DW-1:0] ram_read_data1 = '0, ram_read_data2 = '0;

    always #5 clk = ~clk;

    ram_3port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(INIT_VAL)) dut (
        .clk_i(clk), .rst_i(rst), .init_done_o(init_done),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd1_valid_i(rd1_valid), .rd1_ready_o(rd1_ready), .rd1_addr_i(rd1_addr),
        .rd1_resp_valid_o(rd1_resp_valid), .rd1_resp_data_o(rd1_resp_data),
        .rd2_valid_i(rd2_valid), .rd2_ready_o(rd2_ready), .rd2_addr_i(rd2_addr),
        .rd2_resp_valid_o(rd2_resp_valid), .rd2_resp_data_o(rd2_resp_data),
        .ram_write_en_o(ram_write_en), .ram_write_addr_o(ram_write_addr),
        .ram_write_data_o(ram_write_data),
        .ram_read_addr1_o(ram_read_addr1), .ram_read_addr2_o(ram_read_addr2),
        .ram_read_data1_i(ram_read_data1), .ram_read_data2_i(ram_read_data2)
    );

    // Behavioural register-file RAM: write at the edge, registered reads that
    // see the pre-write word on a collision.
    logic [DW-1:0] ramMem [DEPTH];
    always @(posedge clk) begin
        if (ram_write_en) ramMem[ram_write_addr] <= ram_write_data;
        ram_read_data1 <= ramMem[ram_read_addr1];
        ram_read_data2 <= ramMem[ram_read_addr2];
    end

    // Reference model and scoreboard state.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } resp_t;

    resp_t         expQ1[$];
    resp_t         expQ2[$];
    logic [DW-1:0] refMem [DEPTH];
    int            sweepLeft  = DEPTH;
    int            cycleCnt   = 0;
    int            compared   = 0;
    int            mismatched = 0;
    logic          expReady   = 1'b0;
    logic          expWen     = 1'b0;
    logic [AW-1:0] expWaddr   = '0;
    logic [DW-1:0] expWdata   = '0;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic compare(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    // Combinational outputs of the current cycle against the model.
    task automatic checkOutput();
        compare("init_done", DW'(init_done), DW'(expReady));
        compare("wr_ready", DW'(wr_ready), DW'(expReady));
        compare("rd1_ready", DW'(rd1_ready), DW'(expReady));
        compare("rd2_ready", DW'(rd2_ready), DW'(expReady));
        compare("ram_write_en", DW'(ram_write_en), DW'(expWen));
        if (expWen) begin
            compare("ram_write_addr", DW'(ram_write_addr), DW'(expWaddr));
            compare("ram_write_data", ram_write_data, expWdata);
        end
        compare("ram_read_addr1", DW'(ram_read_addr1), DW'(rd1_addr));
        compare("ram_read_addr2", DW'(ram_read_addr2), DW'(rd2_addr));
    endtask

    // Drive one cycle, advance the model, and check at the falling edge.
    task automatic applyStimulus(input logic r, input logic wv, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input logic r1v, input logic [AW-1:0] r1a,
                                 input logic r2v, input logic [AW-1:0] r2a);
        resp_t item;
        rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd1_valid = r1v; rd1_addr = r1a; rd2_valid = r2v; rd2_addr = r2a;
        if (r) begin
            expReady = 1'b0;
            expWen   = 1'b0;
            expQ1.delete();
            expQ2.delete();
            sweepLeft = DEPTH;
        end else if (sweepLeft > 0) begin
            expReady = 1'b0;
            expWen   = 1'b1;
            expWaddr = AW'(DEPTH - sweepLeft);
            expWdata = INIT_VAL;
            refMem[expWaddr] = INIT_VAL;
            sweepLeft--;
        end else begin
            expReady = 1'b1;
            expWen   = wv;
            expWaddr = wa;
            expWdata = wd;
            if (r1v) begin
                item.due  = cycleCnt + 1;
                item.data = (FWD && wv && wa == r1a) ? wd : refMem[r1a];
                expQ1.push_back(item);
            end
            if (r2v) begin
                item.due  = cycleCnt + 1;
                item.data = (FWD && wv && wa == r2a) ? wd : refMem[r2a];
                expQ2.push_back(item);
            end
            if (wv) refMem[wa] = wd;
        end
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    // Response monitor: pops an expectation when one is due this cycle,
    // otherwise requires a quiet, zeroed response port.
    always @(negedge clk) begin
        if (expQ1.size() > 0 && expQ1[0].due == cycleCnt) begin
            compare("rd1_resp_valid", DW'(rd1_resp_valid), DW'(1'b1));
            compare("rd1_resp_data", rd1_resp_data, expQ1[0].data);
            void'(expQ1.pop_front());
        end else begin
            compare("rd1_resp_valid idle", DW'(rd1_resp_valid), DW'(1'b0));
            compare("rd1_resp_data idle", rd1_resp_data, '0);
        end
        if (expQ2.size() > 0 && expQ2[0].due == cycleCnt) begin
            compare("rd2_resp_valid", DW'(rd2_resp_valid), DW'(1'b1));
            compare("rd2_resp_data", rd2_resp_data, expQ2[0].data);
            void'(expQ2.pop_front());
        end else begin
            compare("rd2_resp_valid idle", DW'(rd2_resp_valid), DW'(1'b0));
            compare("rd2_resp_data idle", rd2_resp_data, '0);
        end
    end

    initial begin
        $display("[TB] start, forwarding=%0d", FWD);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);

        // Init sweep with junk requests that must be ignored.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b0, 1'($urandom), AW'($urandom), {$urandom, $urandom},
                          1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom));
        idle();

        // Last location holds the init word.
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(63), 1'b0, '0);
        idle();

        // Write then read on the next cycle.
        applyStimulus(1'b0, 1'b1, AW'(5), 64'hDEAD_BEEF, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(5), 1'b0, '0);
        idle();

        // Same-cycle collision on rd2.
        applyStimulus(1'b0, 1'b1, AW'(9), 64'h55, 1'b0, '0, 1'b0, '0);
        idle();
        applyStimulus(1'b0, 1'b1, AW'(9), 64'h1234, 1'b0, '0, 1'b1, AW'(9));
        idle();

        // Both channels hammering one address.
        applyStimulus(1'b0, 1'b1, AW'(7), 64'hA5, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(7), 1'b1, AW'(7));
        idle();

        // Random traffic on a narrow address range to provoke collisions.
        for (int i = 0; i < 400; i++)
            applyStimulus(1'b0, 1'($urandom), AW'($urandom_range(0, 15)), {$urandom, $urandom},
                          1'($urandom), AW'($urandom_range(0, 15)),
                          1'($urandom), AW'($urandom_range(0, 15)));
        idle();

        // Reset while a read response is pending, then re-sweep.
        applyStimulus(1'b0, 1'b1, AW'(12), 64'hCAFE, 1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(12), 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, AW'(12), 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) idle();
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, AW'(12), 1'b1, AW'(5));
        for (int i = 0; i < 3; i++) idle();

        compare("rd1 queue drained", DW'(expQ1.size()), '0);
        compare("rd2 queue drained", DW'(expQ2.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
